// File: rtl/flb_band_cal.sv
// flb_band_cal: coarse band calibration for the FLB.
// A request runs a MSB-first successive-approximation search over the 8-bit
// band. Each trial band is allowed to settle, then the DLF output is averaged
// and its sign decides that bit. The FLB SDM is held off while searching, and
// a CSR manual mode overrides the band directly.
module flb_band_cal #(
  parameter int ACC_W = 22
) (
  input  logic        ref_clk_i,
  input  logic        csr_flb_rst_i,
  input  logic        cal_start_i,
  input  logic [15:0] dlf_out_i,
  input  logic [9:0]  csr_flb_cal_settle_i,
  input  logic [1:0]  csr_flb_cal_acc_sel_i,
  input  logic        csr_flb_cal_man_on_i,
  input  logic [7:0]  csr_flb_cal_man_band_i,
  input  logic        csr_flb_sdm_on_i,
  output logic [7:0]  band_o,
  output logic        sdm_on_gated_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic        cal_rail_o
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DECIDE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               res_q, res_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [9:0]               cnt_q, cnt_d;
  logic [6:0]               scnt_q, scnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               band_q, band_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     rail_q, rail_d;
  logic                     sdm_q;

  logic [6:0]               n_minus1;
  logic signed [ACC_W-1:0]  dlf_ext;
  logic [7:0]               res_dec;
  logic [2:0]               bit_next;

  // Averaging length is 4^sel, so the sample counter reloads with 4^sel - 1.
  assign n_minus1 = (7'd1 << {csr_flb_cal_acc_sel_i, 1'b0}) - 7'd1;
  assign dlf_ext  = {{(ACC_W-16){dlf_out_i[15]}}, dlf_out_i};
  // A non-negative average means the DCO is still slow at this trial, so keep the bit.
  assign res_dec  = acc_q[ACC_W-1] ? res_q : (res_q | (8'd1 << bit_idx_q));
  assign bit_next = bit_idx_q - 3'd1;

  // Next-state logic for the search sequencer; manual mode overrides everything.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    acc_d     = acc_q;
    band_d    = band_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rail_d    = rail_q;

    if (csr_flb_cal_man_on_i) begin
      band_d  = csr_flb_cal_man_band_i;
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cal_start_i) begin
            res_d     = 8'h00;
            bit_idx_d = 3'd7;
            band_d    = 8'h80;
            cnt_d     = csr_flb_cal_settle_i;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            rail_d    = 1'b0;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 10'd0) begin
            scnt_d  = n_minus1;
            acc_d   = '0;
            state_d = ACCUM;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
        ACCUM: begin
          acc_d = acc_q + dlf_ext;
          if (scnt_q == 7'd0) begin
            state_d = DECIDE;
          end else begin
            scnt_d = scnt_q - 7'd1;
          end
        end
        DECIDE: begin
          res_d = res_dec;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_next;
            band_d    = res_dec | (8'd1 << bit_next);
            cnt_d     = csr_flb_cal_settle_i;
            state_d   = SETTLE;
          end else begin
            band_d  = res_dec;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rail_d  = (res_dec == 8'h00) || (res_dec == 8'hFF);
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ref_clk_i) begin
    if (csr_flb_rst_i) begin
      state_q   <= IDLE;
      res_q     <= 8'h00;
      bit_idx_q <= 3'd7;
      cnt_q     <= 10'd0;
      scnt_q    <= 7'd0;
      acc_q     <= '0;
      band_q    <= 8'h80;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rail_q    <= 1'b0;
      sdm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      acc_q     <= acc_d;
      band_q    <= band_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rail_q    <= rail_d;
      sdm_q     <= csr_flb_sdm_on_i & ~busy_q;
    end
  end

  assign band_o         = band_q;
  assign sdm_on_gated_o = sdm_q;
  assign cal_busy_o     = busy_q;
  assign cal_done_o     = done_q;
  assign cal_rail_o     = rail_q;

endmodule

// File: tb/tb_flb_band_cal.sv
// Testbench for flb_band_cal: a behavioural search model compared every cycle,
// plus directed scenarios with hand-computed expected values.
module tb_flb_band_cal;

  logic        ref_clk_i = 1'b0;
  logic        csr_flb_rst_i;
  logic        cal_start_i;
  logic [15:0] dlf_out_i;
  logic [9:0]  csr_flb_cal_settle_i;
  logic [1:0]  csr_flb_cal_acc_sel_i;
  logic        csr_flb_cal_man_on_i;
  logic [7:0]  csr_flb_cal_man_band_i;
  logic        csr_flb_sdm_on_i;
  logic [7:0]  band_o;
  logic        sdm_on_gated_o;
  logic        cal_busy_o;
  logic        cal_done_o;
  logic        cal_rail_o;

  int errCount   = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;
  int dlfMode    = 0;

  // Model of the expected outputs.
  logic [7:0] mBand   = 8'h80;
  logic [7:0] mRes    = 8'h00;
  logic       mBusy   = 1'b0;
  logic       mDone   = 1'b0;
  logic       mRail   = 1'b0;
  logic       mSdm    = 1'b0;
  bit         mActive = 1'b0;
  int         mBit, mT, mS, mN, mSum;

  int         trialQ[$];
  logic [7:0] expTrials [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

  flb_band_cal #(.ACC_W(22)) dut (
    .ref_clk_i              (ref_clk_i),
    .csr_flb_rst_i          (csr_flb_rst_i),
    .cal_start_i            (cal_start_i),
    .dlf_out_i              (dlf_out_i),
    .csr_flb_cal_settle_i   (csr_flb_cal_settle_i),
    .csr_flb_cal_acc_sel_i  (csr_flb_cal_acc_sel_i),
    .csr_flb_cal_man_on_i   (csr_flb_cal_man_on_i),
    .csr_flb_cal_man_band_i (csr_flb_cal_man_band_i),
    .csr_flb_sdm_on_i       (csr_flb_sdm_on_i),
    .band_o                 (band_o),
    .sdm_on_gated_o         (sdm_on_gated_o),
    .cal_busy_o             (cal_busy_o),
    .cal_done_o             (cal_done_o),
    .cal_rail_o             (cal_rail_o)
  );

  // Reference clock.
  always #5 ref_clk_i = ~ref_clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs from a negedge and return at the following negedge.
  task automatic applyStimulus(input logic start, input logic manOn, input logic [7:0] manBand, input logic rst);
    cal_start_i            = start;
    csr_flb_cal_man_on_i   = manOn;
    csr_flb_cal_man_band_i = manBand;
    csr_flb_rst_i          = rst;
    @(negedge ref_clk_i);
  endtask

  // Stand-in for the FLB loop: the DLF output as a function of the current band.
  initial begin
    int v;
    dlf_out_i = 16'h0000;
    forever begin
      @(negedge ref_clk_i);
      case (dlfMode)
        0:       v = (32'sh5A - int'(band_o)) * 64;
        1:       v = 1;
        default: v = -1;
      endcase
      dlf_out_i = v[15:0];
    end
  end

  // Behavioural model: timeline of each trial counted from its band change.
  initial begin
    logic nSdm;
    forever begin
      @(posedge ref_clk_i);
      nSdm = csr_flb_sdm_on_i & ~mBusy;
      if (csr_flb_rst_i) begin
        mBand = 8'h80; mBusy = 1'b0; mDone = 1'b0; mRail = 1'b0;
        mActive = 1'b0; nSdm = 1'b0;
      end else if (csr_flb_cal_man_on_i) begin
        mBand = csr_flb_cal_man_band_i; mBusy = 1'b0; mDone = 1'b0; mRail = 1'b0;
        mActive = 1'b0;
      end else if (!mActive) begin
        if (cal_start_i) begin
          mActive = 1'b1; mRes = 8'h00; mBit = 7; mBand = 8'h80;
          mBusy = 1'b1; mDone = 1'b0; mRail = 1'b0;
          mT = 0; mSum = 0; mS = int'(csr_flb_cal_settle_i); mN = 1;
        end
      end else begin
        mT++;
        if (mT == mS + 1) mN = 1 << (2 * int'(csr_flb_cal_acc_sel_i));
        if (mT >= mS + 2 && mT <= mS + mN + 1) mSum += int'($signed(dlf_out_i));
        if (mT == mS + mN + 2) begin
          if (mSum >= 0) mRes[mBit] = 1'b1;
          if (mBit > 0) begin
            mBit--;
            mBand = mRes | (8'd1 << mBit);
            mT = 0; mSum = 0; mS = int'(csr_flb_cal_settle_i);
          end else begin
            mBand = mRes; mBusy = 1'b0; mDone = 1'b1;
            mRail = (mRes == 8'h00) || (mRes == 8'hFF);
            mActive = 1'b0;
          end
        end
      end
      mSdm = nSdm;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge ref_clk_i);
      if (checkEn) begin
        checkOutput("model.band", band_o, mBand);
        checkOutput("model.busy", cal_busy_o, mBusy);
        checkOutput("model.done", cal_done_o, mDone);
        checkOutput("model.sdm", sdm_on_gated_o, mSdm);
        if (mDone) checkOutput("model.rail", cal_rail_o, mRail);
      end
    end
  end

  // Start a search and count edges after the start edge until done rises.
  task automatic runSearch(input logic [9:0] s, input logic [1:0] sel, input int mode,
                           input bit extraStarts, output int doneAt);
    int lastBand;
    csr_flb_cal_settle_i  = s;
    csr_flb_cal_acc_sel_i = sel;
    dlfMode               = mode;
    trialQ.delete();
    lastBand = -1;
    doneAt   = -1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("start.band", band_o, 8'h80);
    checkOutput("start.busy", cal_busy_o, 1'b1);
    checkOutput("start.done", cal_done_o, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      if (cal_busy_o && int'(band_o) != lastBand) begin
        lastBand = int'(band_o);
        trialQ.push_back(lastBand);
      end
      if (cal_done_o) begin
        doneAt = c;
        break;
      end
      applyStimulus(extraStarts && (c == 9 || c == 39 || c == 71), 1'b0, 8'h00, 1'b0);
    end
    if (doneAt < 0) checkOutput("search.timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int doneAt;
    csr_flb_rst_i          = 1'b1;
    cal_start_i            = 1'b0;
    csr_flb_cal_settle_i   = 10'd0;
    csr_flb_cal_acc_sel_i  = 2'd0;
    csr_flb_cal_man_on_i   = 1'b0;
    csr_flb_cal_man_band_i = 8'h00;
    csr_flb_sdm_on_i       = 1'b1;

    // Reset
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("reset.band", band_o, 8'h80);
    checkOutput("reset.busy", cal_busy_o, 1'b0);
    checkOutput("reset.done", cal_done_o, 1'b0);
    checkOutput("reset.rail", cal_rail_o, 1'b0);
    checkOutput("reset.sdm", sdm_on_gated_o, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("idle.sdm", sdm_on_gated_o, 1'b1);

    // Normal search towards 0x5A
    runSearch(10'd3, 2'd1, 0, 1'b0, doneAt);
    checkOutput("normal.doneAt", doneAt, 72);
    checkOutput("normal.band", band_o, 8'h5A);
    checkOutput("normal.rail", cal_rail_o, 1'b0);
    checkOutput("normal.trials", trialQ.size(), 8);
    for (int i = 0; i < 8 && i < trialQ.size(); i++)
      checkOutput($sformatf("normal.trial%0d", i), trialQ[i], expTrials[i]);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Upper rail, then lower rail restarted straight from done
    runSearch(10'd0, 2'd0, 1, 1'b0, doneAt);
    checkOutput("railHi.doneAt", doneAt, 24);
    checkOutput("railHi.band", band_o, 8'hFF);
    checkOutput("railHi.rail", cal_rail_o, 1'b1);
    runSearch(10'd0, 2'd0, 2, 1'b0, doneAt);
    checkOutput("railLo.doneAt", doneAt, 24);
    checkOutput("railLo.band", band_o, 8'h00);
    checkOutput("railLo.rail", cal_rail_o, 1'b1);

    // Start pulses while busy, including the final decide cycle
    runSearch(10'd3, 2'd1, 0, 1'b1, doneAt);
    checkOutput("restart.doneAt", doneAt, 72);
    checkOutput("restart.band", band_o, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("restart.holdDone", cal_done_o, 1'b1);
    checkOutput("restart.holdBusy", cal_busy_o, 1'b0);

    // Manual override during bit 4
    csr_flb_cal_settle_i  = 10'd3;
    csr_flb_cal_acc_sel_i = 2'd1;
    dlfMode               = 0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("manual.preBusy", cal_busy_o, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
    checkOutput("manual.band", band_o, 8'h3C);
    checkOutput("manual.busy", cal_busy_o, 1'b0);
    checkOutput("manual.done", cal_done_o, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h12, 1'b0);
    checkOutput("manual.track", band_o, 8'h12);
    applyStimulus(1'b1, 1'b1, 8'h21, 1'b0);
    checkOutput("manual.winsBand", band_o, 8'h21);
    checkOutput("manual.winsBusy", cal_busy_o, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b0);
    checkOutput("manual.holdBand", band_o, 8'h21);
    runSearch(10'd3, 2'd1, 0, 1'b0, doneAt);
    checkOutput("postManual.doneAt", doneAt, 72);
    checkOutput("postManual.band", band_o, 8'h5A);

    // Reset during the accumulation of bit 2
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 50; c++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("midReset.band", band_o, 8'h80);
    checkOutput("midReset.busy", cal_busy_o, 1'b0);
    checkOutput("midReset.done", cal_done_o, 1'b0);
    checkOutput("midReset.rail", cal_rail_o, 1'b0);
    checkOutput("midReset.sdm", sdm_on_gated_o, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    runSearch(10'd3, 2'd1, 0, 1'b0, doneAt);
    checkOutput("postReset.doneAt", doneAt, 72);
    checkOutput("postReset.band", band_o, 8'h5A);
    checkOutput("postReset.rail", cal_rail_o, 1'b0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Watchdog in case a wait never resolves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errCount);
    $fatal(1, "[TB] watchdog");
  end

endmodule
